// File: rtl/srq_scheduler.sv
// Round-robin service-request scheduler: latches masked chan_srq rising edges and
// offers one pending channel at a time to the CPU via a ready/ack/done handshake.
module srq_scheduler #(
  parameter int NUM_CHANS = 12,
  parameter int IDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CHANS-1:0] chan_srq,
  input  logic                 mask_wr,
  input  logic [NUM_CHANS-1:0] mask_data,
  input  logic                 svc_ack,
  input  logic                 svc_done,
  input  logic                 ovr_clr,
  output logic                 svc_rdy,
  output logic [IDX_W-1:0]     svc_chan,
  output logic [NUM_CHANS-1:0] pending,
  output logic                 busy,
  output logic                 overrun
);

  typedef enum logic [1:0] {IDLE, OFFER, BUSY} state_t;

  state_t               state, state_nxt;
  logic [NUM_CHANS-1:0] srq_d;
  logic [NUM_CHANS-1:0] mask;
  logic [NUM_CHANS-1:0] mask_eff;
  logic [NUM_CHANS-1:0] rise;
  logic [NUM_CHANS-1:0] set_v;
  logic [NUM_CHANS-1:0] ack_vec;
  logic [NUM_CHANS-1:0] pending_nxt;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     sel;
  logic [IDX_W-1:0]     ptr_nxt;
  logic                 sel_vld;
  logic                 withdraw;
  logic                 ack_clr;
  logic                 ovr_set;

  // Returns {found, index} of the first requesting channel at or after start, with wrap.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_CHANS-1:0] req,
                                             input logic [IDX_W-1:0]     start);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] idx;
    int               j;
    res = '0;
    for (int k = 0; k < NUM_CHANS; k++) begin
      j = int'(start) + k;
      if (j >= NUM_CHANS) j = j - NUM_CHANS;
      idx = IDX_W'(j);
      if (!res[IDX_W] && req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign mask_eff    = mask_wr ? mask_data : mask;
  assign rise        = chan_srq & ~srq_d;
  assign set_v       = rise & mask_eff;
  assign withdraw    = (state == OFFER) && mask_wr && !mask_data[svc_chan];
  assign ack_clr     = (state == OFFER) && svc_ack && !withdraw;
  assign ack_vec     = ack_clr ? (NUM_CHANS'(1) << svc_chan) : '0;
  // A same-cycle ack of the channel absorbs the new edge rather than flagging overrun.
  assign ovr_set     = |(set_v & pending & ~ack_vec);
  assign pending_nxt = set_v | (pending & mask_eff & ~ack_vec);
  assign {sel_vld, sel} = rr_pick(pending & mask_eff, ptr);
  assign ptr_nxt     = (svc_chan == IDX_W'(NUM_CHANS - 1)) ? '0 : svc_chan + 1'b1;

  assign svc_rdy = (state == OFFER);
  assign busy    = (state == BUSY);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_vld) state_nxt = OFFER;
      OFFER: begin
        if (withdraw)     state_nxt = IDLE;
        else if (svc_ack) state_nxt = BUSY;
      end
      BUSY:    if (svc_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // srq_d resets high so lines already asserted across reset do not count as edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      srq_d    <= '1;
      mask     <= '0;
      pending  <= '0;
      overrun  <= 1'b0;
      svc_chan <= '0;
      ptr      <= '0;
    end else begin
      srq_d   <= chan_srq;
      mask    <= mask_eff;
      pending <= pending_nxt;
      overrun <= ovr_set | (overrun & ~ovr_clr);
      if (state == IDLE && sel_vld) svc_chan <= sel;
      if (state == BUSY && svc_done) ptr <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_srq_scheduler.sv
// Bench for srq_scheduler: directed scenarios plus random traffic, scored against a
// behavioural model; offers are queued by the model and popped by a monitor.
module tb_srq_scheduler;
  localparam int N  = 12;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  chan_srq = '0;
  logic          mask_wr = 1'b0;
  logic [N-1:0]  mask_data = '0;
  logic          svc_ack = 1'b0;
  logic          svc_done = 1'b0;
  logic          ovr_clr = 1'b0;
  logic          svc_rdy;
  logic [IW-1:0] svc_chan;
  logic [N-1:0]  pending;
  logic          busy;
  logic          overrun;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  srq_scheduler #(.NUM_CHANS(N), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .chan_srq(chan_srq), .mask_wr(mask_wr), .mask_data(mask_data),
    .svc_ack(svc_ack), .svc_done(svc_done), .ovr_clr(ovr_clr), .svc_rdy(svc_rdy),
    .svc_chan(svc_chan), .pending(pending), .busy(busy), .overrun(overrun)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 offering, 2 servicing.
  bit m_pend[N];
  bit m_mask[N];
  bit m_prev[N];
  int m_mode, m_chan, m_ptr;
  bit m_ovr;
  int exp_q[$];

  always @(posedge clk) begin
    bit me[N];
    bit np[N];
    bit wd, ac, ovs, st, cl, found;
    int c;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_mask[i] = 0; m_prev[i] = 1;
      end
      m_mode = 0; m_chan = 0; m_ptr = 0; m_ovr = 0;
      exp_q.delete();
    end else begin
      for (int i = 0; i < N; i++) me[i] = mask_wr ? mask_data[i] : m_mask[i];
      wd  = (m_mode == 1) && mask_wr && !mask_data[m_chan];
      ac  = (m_mode == 1) && svc_ack && !wd;
      ovs = 0;
      for (int i = 0; i < N; i++) begin
        st = chan_srq[i] && !m_prev[i] && me[i];
        cl = ac && (i == m_chan);
        if (st && m_pend[i] && !cl) ovs = 1;
        np[i] = st ? 1'b1 : ((cl || !me[i]) ? 1'b0 : m_pend[i]);
      end
      case (m_mode)
        0: begin
          found = 0;
          for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (!found && m_pend[c] && me[c]) begin
              found = 1; m_mode = 1; m_chan = c; exp_q.push_back(c);
            end
          end
        end
        1: if (wd) m_mode = 0; else if (svc_ack) m_mode = 2;
        default: if (svc_done) begin m_mode = 0; m_ptr = (m_chan + 1) % N; end
      endcase
      for (int i = 0; i < N; i++) begin
        m_pend[i] = np[i]; m_mask[i] = me[i]; m_prev[i] = chan_srq[i];
      end
      m_ovr = ovs ? 1'b1 : (ovr_clr ? 1'b0 : m_ovr);
    end
  end

  // Monitor: per-cycle state comparison plus scoreboard pop on each new offer.
  logic prev_rdy = 1'b0;
  always @(negedge clk) begin
    logic [N-1:0] pp;
    for (int i = 0; i < N; i++) pp[i] = m_pend[i];
    chk("svc_rdy", 32'(svc_rdy), 32'(m_mode == 1));
    chk("busy", 32'(busy), 32'(m_mode == 2));
    chk("svc_chan", 32'(svc_chan), 32'(m_chan));
    chk("pending", 32'(pending), 32'(pp));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    if (svc_rdy && !prev_rdy) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL offer_unexpected actual=%0d required=none", svc_chan);
      end else begin
        chk("offer_chan", 32'(svc_chan), 32'(exp_q.pop_front()));
      end
    end
    prev_rdy = svc_rdy;
  end

  task automatic tick();
    @(posedge clk); #1;
    mask_wr = 0; svc_ack = 0; svc_done = 0; ovr_clr = 0;
  endtask

  task automatic do_reset();
    chan_srq = '0; rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic set_mask(input logic [N-1:0] m);
    mask_data = m; mask_wr = 1; tick();
  endtask

  task automatic wait_rdy(input string nm);
    int n = 0;
    while (!svc_rdy && n < 30) begin tick(); n++; end
    if (!svc_rdy) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=0 required=1", nm);
    end
  endtask

  task automatic serve(input string nm, input int exp);
    wait_rdy(nm);
    chk(nm, 32'(svc_chan), 32'(exp));
    svc_ack = 1; tick();
    svc_done = 1; tick();
  endtask

  int order1[3] = '{3, 5, 11};

  initial begin
    // Reset values and the basic single-channel handshake
    do_reset();
    chk("rst_rdy", 32'(svc_rdy), 0); chk("rst_busy", 32'(busy), 0);
    chk("rst_chan", 32'(svc_chan), 0); chk("rst_pend", 32'(pending), 0);
    chk("rst_ovr", 32'(overrun), 0);
    set_mask(12'h001);
    chan_srq[0] = 1; tick();
    chk("t1_pend", 32'(pending), 32'h001); chk("t1_rdy_early", 32'(svc_rdy), 0);
    tick();
    chk("t1_rdy", 32'(svc_rdy), 1); chk("t1_chan", 32'(svc_chan), 0);
    svc_ack = 1; tick();
    chk("t1_pend_clr", 32'(pending), 0); chk("t1_busy", 32'(busy), 1);
    svc_done = 1; tick();
    chk("t1_idle", 32'(busy), 0); chk("t1_gap", 32'(svc_rdy), 0);

    // Round-robin order and pointer wrap
    do_reset();
    set_mask(12'hFFF);
    chan_srq = 12'h828; tick(); chan_srq = '0;
    for (int i = 0; i < 3; i++) begin
      wait_rdy("rr_order");
      chk("rr_order", 32'(svc_chan), 32'(order1[i]));
      svc_ack = 1; tick();
      if (i == 2) begin
        chan_srq[5] = 1; tick(); chan_srq[0] = 1; tick(); tick();
      end
      svc_done = 1; tick();
    end
    serve("rr_wrap0", 0);
    serve("rr_wrap5", 5);

    // Overrun set/clear and set-beats-ack
    do_reset();
    set_mask(12'hFFF);
    chan_srq[2] = 1; tick(); chan_srq[2] = 0; tick();
    chan_srq[2] = 1; tick();
    chk("ovr_set", 32'(overrun), 1); chk("ovr_offer", 32'(svc_chan), 2);
    ovr_clr = 1; tick();
    chk("ovr_clr", 32'(overrun), 0);
    chan_srq[2] = 0; tick();
    chan_srq[2] = 1; svc_ack = 1; tick();
    chk("ack_set_pend", 32'(pending), 32'h004); chk("ack_set_ovr", 32'(overrun), 0);
    chk("ack_set_busy", 32'(busy), 1);
    svc_done = 1; tick();
    serve("ack_set_reoffer", 2);

    // Withdrawal of an offer by masking, with a same-cycle ack
    do_reset();
    set_mask(12'hFFF);
    chan_srq[4] = 1; tick(); tick();
    chk("wd_rdy", 32'(svc_rdy), 1); chk("wd_chan", 32'(svc_chan), 4);
    mask_data = 12'hFEF; mask_wr = 1; svc_ack = 1; tick();
    chk("wd_drop", 32'(svc_rdy), 0); chk("wd_pend", 32'(pending), 0);
    chk("wd_nobusy", 32'(busy), 0);

    // Fully masked channels discard edges
    do_reset();
    chan_srq = 12'hFFF; tick(); chan_srq = '0; tick(); chan_srq = 12'hFFF;
    repeat (4) tick();
    chk("msk_pend", 32'(pending), 0); chk("msk_rdy", 32'(svc_rdy), 0);
    chk("msk_ovr", 32'(overrun), 0);

    // Reset while busy with lines held high
    do_reset();
    set_mask(12'hFFF);
    chan_srq = 12'hFFF; tick();
    wait_rdy("rb_offer");
    svc_ack = 1; tick();
    chk("rb_busy", 32'(busy), 1);
    rst = 1; tick(); rst = 0;
    chk("rb_busy0", 32'(busy), 0); chk("rb_pend0", 32'(pending), 0);
    chk("rb_chan0", 32'(svc_chan), 0);
    set_mask(12'hFFF);
    repeat (5) tick();
    chk("rb_no_offer", 32'(svc_rdy), 0);

    // Random traffic
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(15) == 0) chan_srq[i] = ~chan_srq[i];
      if ($urandom_range(39) == 0) begin
        mask_wr = 1; mask_data = N'($urandom | $urandom);
      end
      svc_ack  = svc_rdy ? ($urandom_range(2) == 0) : ($urandom_range(29) == 0);
      svc_done = busy ? ($urandom_range(3) == 0) : ($urandom_range(29) == 0);
      ovr_clr  = ($urandom_range(49) == 0);
      rst      = ($urandom_range(799) == 0);
      tick();
    end
    rst = 0;
    tick();
    @(negedge clk); #1;
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
